// File: rtl/trdb_packet_decoder.sv
// Trace packet decoder: reassembles length-prefixed byte streams into packets and
// decodes the E-Trace format/subformat fields carried in the first payload byte.

package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'b00,
        F_DIFF_DELTA = 2'b01,
        F_ADDR_ONLY  = 2'b10,
        F_SYNC       = 2'b11
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'b00,
        SF_TRAP    = 2'b01,
        SF_CONTEXT = 2'b10,
        SF_SUPPORT = 2'b11
    } trdb_f_sync_subformat_e;

    typedef enum logic {
        SF_PBC = 1'b0,
        SF_JTC = 1'b1
    } trdb_f_opt_ext_subformat_e;

endpackage

module trdb_packet_decoder
    import trdb_pkg::*;
#(
    parameter int MAX_BYTES = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      byte_valid_i,
    input  logic [7:0]                byte_i,
    output logic                      byte_ready_o,
    output logic                      pkt_valid_o,
    input  logic                      pkt_ready_i,
    output trdb_format_e              packet_format_o,
    output trdb_f_sync_subformat_e    packet_f_sync_subformat_o,
    output trdb_f_opt_ext_subformat_e packet_f_opt_ext_subformat_o,
    output logic [8*MAX_BYTES-1:0]    payload_o,
    output logic [4:0]                payload_len_o,
    output logic                      len_error_o,
    output logic [15:0]               pkt_count_o
);

    localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);

    typedef enum logic [1:0] {
        HEADER  = 2'b00,
        PAYLOAD = 2'b01,
        OUTPUT  = 2'b10
    } state_e;

    state_e                 state_q;
    logic                   byte_ready_q;
    logic                   pkt_valid_q;
    logic [4:0]             len_q;
    logic [4:0]             idx_q;
    logic [8*MAX_BYTES-1:0] payload_q;
    logic                   len_error_q;
    logic [15:0]            pkt_count_q;

    logic [4:0] header_len;
    logic       header_ok;
    logic       byte_xfer;
    logic       last_byte;

    assign header_len = byte_i[4:0];
    assign header_ok  = (header_len != 5'd0) && (header_len <= MAX_LEN);
    assign byte_xfer  = byte_valid_i && byte_ready_q;
    assign last_byte  = (idx_q == (len_q - 5'd1));

    // Handshake flags are registered per state so byte_ready_o never sees pkt_ready_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HEADER;
            byte_ready_q <= 1'b1;
            pkt_valid_q  <= 1'b0;
            len_q        <= 5'd0;
            idx_q        <= 5'd0;
            payload_q    <= '0;
            len_error_q  <= 1'b0;
            pkt_count_q  <= 16'd0;
        end else begin
            len_error_q <= 1'b0;
            case (state_q)
                HEADER: begin
                    if (byte_xfer) begin
                        if (header_ok) begin
                            len_q     <= header_len;
                            idx_q     <= 5'd0;
                            payload_q <= '0;
                            state_q   <= PAYLOAD;
                        end else begin
                            len_error_q <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_xfer) begin
                        for (int k = 0; k < MAX_BYTES; k++) begin
                            if (idx_q == 5'(k)) begin
                                payload_q[8*k +: 8] <= byte_i;
                            end
                        end
                        idx_q <= idx_q + 5'd1;
                        if (last_byte) begin
                            state_q      <= OUTPUT;
                            byte_ready_q <= 1'b0;
                            pkt_valid_q  <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (pkt_ready_i) begin
                        state_q      <= HEADER;
                        byte_ready_q <= 1'b1;
                        pkt_valid_q  <= 1'b0;
                        pkt_count_q  <= pkt_count_q + 16'd1;
                    end
                end
                default: begin
                    state_q      <= HEADER;
                    byte_ready_q <= 1'b1;
                    pkt_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Subformat fields are only defined for their own format; otherwise report the zero code.
    always_comb begin
        trdb_format_e fmt;
        fmt                          = trdb_format_e'(payload_q[1:0]);
        packet_format_o              = fmt;
        packet_f_sync_subformat_o    = SF_START;
        packet_f_opt_ext_subformat_o = SF_PBC;
        if (fmt == F_SYNC) begin
            packet_f_sync_subformat_o = trdb_f_sync_subformat_e'(payload_q[3:2]);
        end
        if (fmt == F_OPT_EXT) begin
            packet_f_opt_ext_subformat_o = trdb_f_opt_ext_subformat_e'(payload_q[2]);
        end
    end

    assign byte_ready_o  = byte_ready_q;
    assign pkt_valid_o   = pkt_valid_q;
    assign payload_o     = payload_q;
    assign payload_len_o = len_q;
    assign len_error_o   = len_error_q;
    assign pkt_count_o   = pkt_count_q;

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Self-checking bench for trdb_packet_decoder: a byte-stream model checked every
// cycle, plus directed packets with hand-computed expectations.

module tb_trdb_packet_decoder;
    import trdb_pkg::*;

    localparam int MAX_BYTES = 24;
    localparam int W         = 8 * MAX_BYTES;

    logic                      clk = 1'b0;
    logic                      rst_ni = 1'b1;
    logic                      byte_valid_i = 1'b0;
    logic [7:0]                byte_i = 8'h00;
    logic                      pkt_ready_i = 1'b1;
    logic                      byte_ready_o;
    logic                      pkt_valid_o;
    trdb_format_e              packet_format_o;
    trdb_f_sync_subformat_e    packet_f_sync_subformat_o;
    trdb_f_opt_ext_subformat_e packet_f_opt_ext_subformat_o;
    logic [W-1:0]              payload_o;
    logic [4:0]                payload_len_o;
    logic                      len_error_o;
    logic [15:0]               pkt_count_o;

    int   errors = 0;
    int   checks = 0;
    logic preload_req = 1'b0;

    // Stream-level model: bytes still owed to the current packet, the bytes seen so far,
    // whether a finished packet is waiting for the consumer, and the delivered count.
    int          m_remaining = 0;
    int          m_idx = 0;
    int          m_len = 0;
    bit          m_pending = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_count = 16'd0;
    logic [7:0]  m_buf [MAX_BYTES];

    trdb_packet_decoder #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk_i                        (clk),
        .rst_ni                       (rst_ni),
        .byte_valid_i                 (byte_valid_i),
        .byte_i                       (byte_i),
        .byte_ready_o                 (byte_ready_o),
        .pkt_valid_o                  (pkt_valid_o),
        .pkt_ready_i                  (pkt_ready_i),
        .packet_format_o              (packet_format_o),
        .packet_f_sync_subformat_o    (packet_f_sync_subformat_o),
        .packet_f_opt_ext_subformat_o (packet_f_opt_ext_subformat_o),
        .payload_o                    (payload_o),
        .payload_len_o                (payload_len_o),
        .len_error_o                  (len_error_o),
        .pkt_count_o                  (pkt_count_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one byte after an idle gap and holds it until the decoder takes it.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit accepted;
        byte_valid_i = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        accepted     = 1'b0;
        for (int t = 0; t < 100 && !accepted; t++) begin
            accepted = byte_ready_o;
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_accept: byte %0h got no handshake, expected acceptance within 100 cycles", b);
        end
    endtask

    // Every cycle: compare the DUT against the model, then advance the model by whatever
    // handshakes will happen at the coming rising edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_payload;
        int           n;
        int           b0;
        int           fmt;
        int           sync_sf;
        int           opt_sf;
        if (!rst_ni) begin
            checkOutput("rst_byte_ready", W'(byte_ready_o), W'(1));
            checkOutput("rst_pkt_valid", W'(pkt_valid_o), W'(0));
            checkOutput("rst_len_error", W'(len_error_o), W'(0));
            checkOutput("rst_pkt_count", W'(pkt_count_o), W'(0));
            checkOutput("rst_payload", payload_o, W'(0));
            checkOutput("rst_payload_len", W'(payload_len_o), W'(0));
            checkOutput("rst_format", W'(packet_format_o), W'(2'd0));
            checkOutput("rst_sync_sf", W'(packet_f_sync_subformat_o), W'(2'd0));
            checkOutput("rst_opt_sf", W'(packet_f_opt_ext_subformat_o), W'(1'b0));
            m_remaining = 0;
            m_idx       = 0;
            m_len       = 0;
            m_pending   = 1'b0;
            m_err       = 1'b0;
            m_count     = 16'd0;
            for (int k = 0; k < MAX_BYTES; k++) m_buf[k] = 8'h00;
        end else begin
            checkOutput("byte_ready", W'(byte_ready_o), W'(!m_pending));
            checkOutput("pkt_valid", W'(pkt_valid_o), W'(m_pending));
            checkOutput("len_error", W'(len_error_o), W'(m_err));
            checkOutput("pkt_count", W'(pkt_count_o), W'(m_count));
            if (m_pending) begin
                exp_payload = '0;
                for (int k = 0; k < MAX_BYTES; k++) exp_payload[8*k +: 8] = m_buf[k];
                b0      = int'(m_buf[0]);
                fmt     = b0 % 4;
                sync_sf = (fmt == 3) ? (b0 / 4) % 4 : 0;
                opt_sf  = (fmt == 0) ? (b0 / 4) % 2 : 0;
                checkOutput("payload", payload_o, exp_payload);
                checkOutput("payload_len", W'(payload_len_o), W'(m_len));
                checkOutput("format", W'(packet_format_o), W'(fmt));
                checkOutput("sync_sf", W'(packet_f_sync_subformat_o), W'(sync_sf));
                checkOutput("opt_sf", W'(packet_f_opt_ext_subformat_o), W'(opt_sf));
            end
            m_err = 1'b0;
            if (m_pending) begin
                if (pkt_ready_i) begin
                    m_pending = 1'b0;
                    m_count   = m_count + 16'd1;
                end
            end else if (byte_valid_i) begin
                if (m_remaining == 0) begin
                    n = int'(byte_i) % 32;
                    if (n == 0 || n > MAX_BYTES) begin
                        m_err = 1'b1;
                    end else begin
                        m_remaining = n;
                        m_len       = n;
                        m_idx       = 0;
                        for (int k = 0; k < MAX_BYTES; k++) m_buf[k] = 8'h00;
                    end
                end else begin
                    m_buf[m_idx] = byte_i;
                    m_idx++;
                    m_remaining--;
                    if (m_remaining == 0) m_pending = 1'b1;
                end
            end
            if (preload_req) begin
                force dut.pkt_count_q = 16'hFFFF;
                release dut.pkt_count_q;
                m_count = 16'hFFFF;
            end
        end
    end

    initial begin
        int n;
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        checkOutput("reset_byte_ready", W'(byte_ready_o), W'(1));
        checkOutput("reset_pkt_count", W'(pkt_count_o), W'(0));

        // Two-byte sync/trap packet: 0x07 -> format 3, subformat 1.
        applyStimulus(8'h02, 0);
        applyStimulus(8'h07, 0);
        applyStimulus(8'hAB, 0);
        checkOutput("sync_valid", W'(pkt_valid_o), W'(1));
        checkOutput("sync_format", W'(packet_format_o), W'(2'd3));
        checkOutput("sync_trap", W'(packet_f_sync_subformat_o), W'(2'd1));
        checkOutput("sync_len", W'(payload_len_o), W'(2));
        checkOutput("sync_payload", W'(payload_o[15:0]), W'(16'hAB07));
        @(posedge clk);
        #1;
        checkOutput("sync_count", W'(pkt_count_o), W'(1));
        checkOutput("sync_done", W'(pkt_valid_o), W'(0));

        // Illegal headers (N=0, N=25) pulse len_error and are skipped.
        applyStimulus(8'h00, 0);
        checkOutput("err0_pulse", W'(len_error_o), W'(1));
        @(posedge clk);
        #1;
        checkOutput("err0_clear", W'(len_error_o), W'(0));
        applyStimulus(8'h19, 0);
        checkOutput("err25_pulse", W'(len_error_o), W'(1));
        checkOutput("err25_no_pkt", W'(pkt_valid_o), W'(0));
        applyStimulus(8'h01, 0);
        applyStimulus(8'h04, 0);
        checkOutput("optext_format", W'(packet_format_o), W'(2'd0));
        checkOutput("optext_jtc", W'(packet_f_opt_ext_subformat_o), W'(1'b1));
        checkOutput("optext_sync_sf", W'(packet_f_sync_subformat_o), W'(2'd0));

        // Consumer back-pressure: packet held, pending byte not consumed.
        applyStimulus(8'h03, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        pkt_ready_i = 1'b0;
        applyStimulus(8'h33, 0);
        byte_valid_i = 1'b1;
        byte_i       = 8'h55;
        repeat (10) begin
            checkOutput("hold_valid", W'(pkt_valid_o), W'(1));
            checkOutput("hold_ready", W'(byte_ready_o), W'(0));
            checkOutput("hold_payload", W'(payload_o[23:0]), W'(24'h332211));
            checkOutput("hold_format", W'(packet_format_o), W'(2'd1));
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
        pkt_ready_i  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", W'(pkt_valid_o), W'(0));
        checkOutput("release_ready", W'(byte_ready_o), W'(1));
        checkOutput("release_count", W'(pkt_count_o), W'(3));

        // Reset after 3 of 5 payload bytes discards the partial packet.
        applyStimulus(8'h05, 0);
        applyStimulus(8'hA1, 0);
        applyStimulus(8'hA2, 1);
        applyStimulus(8'hA3, 0);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_count", W'(pkt_count_o), W'(0));
        checkOutput("midrst_payload", payload_o, W'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        applyStimulus(8'h01, 0);
        applyStimulus(8'hC3, 0);
        checkOutput("after_rst_format", W'(packet_format_o), W'(2'd3));
        checkOutput("after_rst_sync", W'(packet_f_sync_subformat_o), W'(2'd0));
        checkOutput("after_rst_payload", W'(payload_o[7:0]), W'(8'hC3));
        @(posedge clk);
        #1;
        checkOutput("after_rst_count", W'(pkt_count_o), W'(1));

        // 1000 random packets with random gaps and random ignored header bits.
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            n = $urandom_range(1, MAX_BYTES);
            applyStimulus(8'(n) | 8'($urandom_range(0, 7) << 5), $urandom_range(0, 2));
            for (int k = 0; k < n; k++) begin
                applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("random_count", W'(pkt_count_o), W'(1000));

        // Counter wrap from 16'hFFFF.
        preload_req = 1'b1;
        @(posedge clk);
        #1;
        preload_req = 1'b0;
        checkOutput("preload_count", W'(pkt_count_o), W'(16'hFFFF));
        applyStimulus(8'h01, 0);
        applyStimulus(8'h5A, 0);
        @(posedge clk);
        #1;
        checkOutput("wrap_count", W'(pkt_count_o), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
